// File: rtl/seg7_scan_controller_if.sv
// Load/ready handshake carrying four hex digits with per-digit blank and
// decimal-point flags from the datapath to the display scanner.
interface seg7_scan_controller_if;
   logic        load;
   logic        ready;
   logic [15:0] data_in;
   logic [3:0]  blank_in;
   logic [3:0]  dp_in;

   modport master (
      output load,
      output data_in,
      output blank_in,
      output dp_in,
      input  ready
   );

   modport slave (
      input  load,
      input  data_in,
      input  blank_in,
      input  dp_in,
      output ready
   );
endinterface

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment scanner: hex decode, per-digit ON/GUARD
// timing and a frame-aligned shadow register so displayed digits never tear.
module seg7_scan_controller #(
   parameter int unsigned ON_CYCLES    = 50000,
   parameter int unsigned GUARD_CYCLES = 500
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   seg7_scan_controller_if.slave  bus,
   output logic [6:0]             seg,
   output logic                   dp_n,
   output logic [3:0]             transistor,
   output logic [1:0]             digit_sel,
   output logic                   frame_done
);

   localparam int unsigned CNT_MAX = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
   localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam bit            NO_GUARD   = (GUARD_CYCLES == 0);

   typedef enum logic [1:0] {
      S_OFF,
      S_GUARD,
      S_ON
   } state_t;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  blank;
      logic [3:0]  dp;
   } disp_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   disp_t         active_q, active_d;
   disp_t         pending_q, pending_d;
   logic          pending_valid_q, pending_valid_d;
   logic          ready_q, ready_d;
   logic          frame_done_d;
   logic [6:0]    seg_d;
   logic          dp_n_d;
   logic [3:0]    transistor_d;
   logic          capture;
   logic          transfer;
   logic [3:0]    nibble;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign capture = bus.load & ready_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      digit_d      = digit_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         S_OFF: begin
            cnt_d   = '0;
            digit_d = 2'd0;
            if (enable) state_d = NO_GUARD ? S_ON : S_GUARD;
         end
         S_GUARD: begin
            if (!enable) begin
               state_d = S_OFF;
               cnt_d   = '0;
               digit_d = 2'd0;
            end else if (cnt_q == GUARD_LAST) begin
               state_d = S_ON;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ON: begin
            if (!enable) begin
               state_d = S_OFF;
               cnt_d   = '0;
               digit_d = 2'd0;
            end else if (cnt_q == ON_LAST) begin
               state_d      = NO_GUARD ? S_ON : S_GUARD;
               cnt_d        = '0;
               digit_d      = digit_q + 2'd1;
               frame_done_d = (digit_q == 2'd3);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
            digit_d = 2'd0;
         end
      endcase

      // Shadow data moves to the display only at a frame edge, or at once while dark.
      transfer        = pending_valid_q & (frame_done_d | (state_q == S_OFF));
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      active_d        = active_q;
      ready_d         = ~pending_valid_q;

      if (capture) begin
         pending_d       = '{data: bus.data_in, blank: bus.blank_in, dp: bus.dp_in};
         pending_valid_d = 1'b1;
         ready_d         = 1'b0;
      end
      if (transfer) begin
         active_d        = pending_q;
         pending_valid_d = 1'b0;
      end

      // Output registers are loaded from next-state values so they line up with the FSM.
      nibble       = active_d.data[{digit_d, 2'b00} +: 4];
      seg_d        = 7'b1111111;
      dp_n_d       = 1'b1;
      transistor_d = 4'b1111;
      if (state_d == S_ON) begin
         transistor_d = ~(4'b0001 << digit_d);
         seg_d        = active_d.blank[digit_d] ? 7'b1111111 : hex_to_seg(nibble);
         dp_n_d       = ~active_d.dp[digit_d];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q         <= S_OFF;
         cnt_q           <= '0;
         digit_q         <= 2'd0;
         active_q        <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         ready_q         <= 1'b1;
         frame_done      <= 1'b0;
         seg             <= 7'b1111111;
         dp_n            <= 1'b1;
         transistor      <= 4'b1111;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         digit_q         <= digit_d;
         active_q        <= active_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         ready_q         <= ready_d;
         frame_done      <= frame_done_d;
         seg             <= seg_d;
         dp_n            <= dp_n_d;
         transistor      <= transistor_d;
      end
   end

   assign digit_sel = digit_q;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: one instance with a guard interval,
// one without, checked cycle by cycle against hand-derived scan patterns.
module tb_seg7_scan_controller;

   localparam int NO_LOAD = 100;
   localparam int NO_STOP = 99;

   localparam logic [6:0] SEG_TBL [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       enable1;
   logic [6:0] seg0, seg1;
   logic       dp_n0, dp_n1;
   logic [3:0] tr0, tr1;
   logic [1:0] ds0, ds1;
   logic       fd0, fd1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seg7_scan_controller_if bus0 ();
   seg7_scan_controller_if bus1 ();

   seg7_scan_controller #(.ON_CYCLES(4), .GUARD_CYCLES(1)) u0 (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .bus        (bus0),
      .seg        (seg0),
      .dp_n       (dp_n0),
      .transistor (tr0),
      .digit_sel  (ds0),
      .frame_done (fd0)
   );

   seg7_scan_controller #(.ON_CYCLES(4), .GUARD_CYCLES(0)) u1 (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable1),
      .bus        (bus1),
      .seg        (seg1),
      .dp_n       (dp_n1),
      .transistor (tr1),
      .digit_sel  (ds1),
      .frame_done (fd1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_seg"},        {25'd0, seg0},  32'h7F);
      check({tag, "_dp_n"},       {31'd0, dp_n0}, 32'h1);
      check({tag, "_transistor"}, {28'd0, tr0},   32'hF);
      check({tag, "_digit_sel"},  {30'd0, ds0},   32'h0);
      check({tag, "_frame_done"}, {31'd0, fd0},   32'h0);
      check({tag, "_ready"},      {31'd0, bus0.ready}, 32'h1);
   endtask

   task automatic check_dark(input string tag);
      check({tag, "_transistor"}, {28'd0, tr0},   32'hF);
      check({tag, "_digit_sel"},  {30'd0, ds0},   32'h0);
      check({tag, "_seg"},        {25'd0, seg0},  32'h7F);
      check({tag, "_dp_n"},       {31'd0, dp_n0}, 32'h1);
      check({tag, "_frame_done"}, {31'd0, fd0},   32'h0);
   endtask

   // Samples one frame of u0 starting at the guard before digit 0:
   // index 5*d is digit d's guard, 5*d+1 .. 5*d+4 its ON window.
   task automatic frame(input logic [15:0] data, input logic [3:0] blank, input logic [3:0] dp,
                        input bit fd_first, input bit chk_rdy,
                        input int load_idx, input logic [15:0] load_data,
                        input logic [3:0] load_blank, input logic [3:0] load_dp,
                        input int stop_idx);
      int         d;
      bit         on;
      logic [3:0] exp_tr;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic [3:0] nib;
      for (int idx = 0; idx < 20; idx++) begin
         d  = idx / 5;
         on = (idx % 5) != 0;
         @(negedge clk);
         if (on) begin
            nib     = data[d*4 +: 4];
            exp_tr  = ~(4'b0001 << d);
            exp_seg = blank[d] ? 7'h7F : SEG_TBL[nib];
            exp_dp  = ~dp[d];
         end else begin
            exp_tr  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
         end
         check("transistor", {28'd0, tr0},   {28'd0, exp_tr});
         check("digit_sel",  {30'd0, ds0},   d);
         check("seg",        {25'd0, seg0},  {25'd0, exp_seg});
         check("dp_n",       {31'd0, dp_n0}, {31'd0, exp_dp});
         check("frame_done", {31'd0, fd0},   {31'd0, (idx == 0) && fd_first});
         if (chk_rdy && idx == 0) check("ready_at_frame_done", {31'd0, bus0.ready}, 32'h0);
         if (chk_rdy && idx == 1) check("ready_after_frame_done", {31'd0, bus0.ready}, 32'h1);
         if (idx == load_idx) begin
            bus0.load     = 1'b1;
            bus0.data_in  = load_data;
            bus0.blank_in = load_blank;
            bus0.dp_in    = load_dp;
         end
         if (idx == load_idx + 1) begin
            check("ready_after_load", {31'd0, bus0.ready}, 32'h0);
            // Held load with junk while ready=0 must be ignored.
            bus0.data_in  = 16'h5555;
            bus0.blank_in = 4'h0;
            bus0.dp_in    = 4'hF;
         end
         if (idx == load_idx + 2) bus0.load = 1'b0;
         if (idx == stop_idx) break;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         d;
      logic [3:0] nib;
      logic [15:0] g0_data;

      rst           = 1'b1;
      enable        = 1'b0;
      enable1       = 1'b0;
      bus0.load     = 1'b0;
      bus0.data_in  = 16'h0;
      bus0.blank_in = 4'h0;
      bus0.dp_in    = 4'h0;
      bus1.load     = 1'b0;
      bus1.data_in  = 16'h0;
      bus1.blank_in = 4'h0;
      bus1.dp_in    = 4'h0;
      repeat (3) @(negedge clk);
      check_reset("reset");

      // Load while dark: capture, transfer next cycle, ready back after that.
      rst          = 1'b0;
      bus0.load    = 1'b1;
      bus0.data_in = 16'h3210;
      @(negedge clk);
      check("off_ready_after_capture", {31'd0, bus0.ready}, 32'h0);
      bus0.load = 1'b0;
      @(negedge clk);
      check("off_ready_transfer_cycle", {31'd0, bus0.ready}, 32'h0);
      @(negedge clk);
      check("off_ready_restored", {31'd0, bus0.ready}, 32'h1);
      enable = 1'b1;

      frame(16'h3210, 4'h0, 4'h0, 1'b0, 1'b0, NO_LOAD, 16'h0, 4'h0, 4'h0, NO_STOP);
      frame(16'h3210, 4'h0, 4'h0, 1'b1, 1'b0, 6, 16'hFEDC, 4'h0, 4'h0, NO_STOP);
      frame(16'hFEDC, 4'h0, 4'h0, 1'b1, 1'b1, 6, 16'h8888, 4'b1010, 4'b0001, NO_STOP);
      frame(16'h8888, 4'b1010, 4'b0001, 1'b1, 1'b1, NO_LOAD, 16'h0, 4'h0, 4'h0, NO_STOP);

      // Drop enable during digit 2's ON window.
      frame(16'h8888, 4'b1010, 4'b0001, 1'b1, 1'b0, NO_LOAD, 16'h0, 4'h0, 4'h0, 12);
      enable = 1'b0;
      @(negedge clk);
      check_dark("disable_next");
      @(negedge clk);
      check_dark("disable_hold");
      enable = 1'b1;
      frame(16'h8888, 4'b1010, 4'b0001, 1'b0, 1'b0, NO_LOAD, 16'h0, 4'h0, 4'h0, NO_STOP);

      // Reset mid-ON with a pending load outstanding.
      frame(16'h8888, 4'b1010, 4'b0001, 1'b1, 1'b0, 6, 16'h1234, 4'h0, 4'h0, 8);
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid_scan_reset");
      rst = 1'b0;
      frame(16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, NO_LOAD, 16'h0, 4'h0, 4'h0, NO_STOP);
      check("ready_after_reset_frame", {31'd0, bus0.ready}, 32'h1);
      frame(16'h0000, 4'h0, 4'h0, 1'b1, 1'b0, NO_LOAD, 16'h0, 4'h0, 4'h0, 4);

      // No guard interval: digits rotate every 4 cycles with no dark gap.
      g0_data      = 16'h3210;
      bus1.load    = 1'b1;
      bus1.data_in = g0_data;
      @(negedge clk);
      bus1.load = 1'b0;
      repeat (2) @(negedge clk);
      check("g0_ready_restored", {31'd0, bus1.ready}, 32'h1);
      enable1 = 1'b1;
      for (int k = 0; k < 21; k++) begin
         d   = (k / 4) % 4;
         nib = g0_data[d*4 +: 4];
         @(negedge clk);
         check("g0_transistor", {28'd0, tr1},  {28'd0, ~(4'b0001 << d)});
         check("g0_digit_sel",  {30'd0, ds1},  d);
         check("g0_seg",        {25'd0, seg1}, {25'd0, SEG_TBL[nib]});
         check("g0_frame_done", {31'd0, fd1},  {31'd0, k == 16});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes four hex digits onto one shared 7-segment bus and four active-low digit transistors.
- Contains the hex-to-segment decode and a per-digit scan state machine with an anti-ghosting guard interval.
- Has a load/ready handshake whose shadow register updates only at frame boundaries, so digits never tear.
- Sits between the counter/datapath logic and the board display pins.

Parameters:
- ON_CYCLES, 50000: clock cycles each digit is lit; legal range 1 to 2^20-1.
- GUARD_CYCLES, 500: cycles with all transistors off between digits; 0 means no guard interval.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  1 = scan display, 0 = display dark.
- load  input  1  request to capture new display data.
- ready  output  1  load is accepted on a cycle where load=1 and ready=1.
- data_in  input  16  digit3..digit0 nibbles; [3:0] is digit 0.
- blank_in  input  4  per-digit blank; 1 = segments off for that digit.
- dp_in  input  4  per-digit decimal point; 1 = lit.
- seg  output  7  {a,b,c,d,e,f,g}, active-low.
- dp_n  output  1  decimal point, active-low.
- transistor  output  4  digit enables, active-low one-hot; bit i drives digit i.
- digit_sel  output  2  index of the current digit.
- frame_done  output  1  one-cycle pulse at the end of digit 3's ON interval.

Behaviour:
- All outputs registered.
- Reset values: seg=7'b1111111, dp_n=1, transistor=4'b1111, digit_sel=0, frame_done=0, ready=1; FSM=OFF, counter=0, active and pending registers cleared, pending_valid=0.
- Reset has priority over every other input at every point, including mid-scan.
- States:
  - OFF: all dark. If enable=1, go to GUARD, or to ON when GUARD_CYCLES=0, with digit_sel=0.
  - GUARD: transistor=1111, seg all off. Stay exactly GUARD_CYCLES cycles, then ON.
  - ON: transistor bit digit_sel=0, others 1. Stay exactly ON_CYCLES cycles. On the last cycle, next digit_sel = digit_sel+1, wrapping 3->0. Then GUARD, or ON directly when GUARD_CYCLES=0.
- seg in ON state: decode(active nibble), or 7'b1111111 if the blank bit is set. dp_n = ~dp bit; dp is independent of blank.
- Decode table (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- frame_done: high for one cycle, on the cycle after the last ON cycle of digit 3.
- Handshake:
  - When load & ready, capture {data_in, blank_in, dp_in} into pending; pending_valid=1; ready=0 from the next cycle.
  - Transfer pending->active on the frame_done cycle; pending_valid clears there and ready=1 the following cycle.
  - In OFF, a pending transfer happens on the cycle after capture.
  - load while ready=0 is ignored.
- enable falling in any state: next cycle enter OFF; dark outputs, digit_sel=0, counter=0, frame_done=0. A pending load remains and transfers per the OFF rule.
- Counter width: ceil(log2(max(ON_CYCLES,GUARD_CYCLES)+1)). It reloads to 0 on every state entry.
- Frame period = 4*(ON_CYCLES+GUARD_CYCLES) cycles.

Test Plan:
- ON_CYCLES=4, GUARD_CYCLES=1. Sequence: reset, enable=1, load data_in=16'h3210, blank=0, dp=0.
  - Expect, after transfer: transistor cycles 1111(1), 1110(4), 1111(1), 1101(4), 1111(1), 1011(4), 1111(1), 0111(4).
  - Expect seg 0000001/1001111/0010010/0000110 in the matching ON windows.
  - Expect frame_done every 20 cycles.
- Load 16'hFEDC mid-frame (during digit 1).
  - ready=0 the next cycle.
  - Old digits are shown until frame_done.
  - The following frame shows 0111000/0110000/1000010/0110001 on digits 3..0.
  - ready=1 the cycle after frame_done.
- blank_in=4'b1010, dp_in=4'b0001, data 16'h8888.
  - Digits 1 and 3: seg=1111111 with their transistor still low.
  - Digit 0: dp_n=0 and seg=0000000.
- enable deasserted during digit 2's ON interval: next cycle transistor=1111, digit_sel=0. Re-enabling restarts at a GUARD then digit 0.
- rst asserted mid-ON interval with pending_valid=1: next cycle all reset values, ready=1, and display data is cleared to 0.
- GUARD_CYCLES=0: transistor never reads 1111 between digits while enabled; the digits rotate every 4 cycles.
